// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg -- shared definitions for the processing-element controller.
//
// Contents:
//   K_W_DEF      default width of the operand-count field
//   ACT_LAT_DEF  default activation-unit latency in cycles
//   state_t      controller FSM state encoding
//   cnt_width()  bits needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam int K_W_DEF     = 8;
  localparam int ACT_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_ACT,
    ST_OUT
  } state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pe_cnt.sv
// -----------------------------------------------------------------------------
// pe_cnt -- loadable down-counter with zero and one flags.
//
// Used by pe_ctrl both for the per-job operand counter and for the activation
// wait counter. The counter itself never guards against underflow; the caller
// gates dec with ~zero so the count can never wrap.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset, clears the count
//   load      load load_val (takes priority over dec)
//   load_val  value to load
//   dec       decrement by one
//   zero      count == 0
//   one       count == 1 (the next decrement reaches zero)
// -----------------------------------------------------------------------------
module pe_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);
  assign one  = (count == ONE);

endmodule

// File: rtl/pe_ctrl.sv
// -----------------------------------------------------------------------------
// pe_ctrl -- job sequencer for one processing element.
//
// A job is accepted in IDLE on start: the accumulator is cleared for one cycle
// (CLR), k_len operands are accepted from the input stream (LOAD), the result
// optionally waits ACT_LAT cycles for the activation unit (ACT), and is then
// presented until the consumer takes it (OUT). done pulses in the IDLE cycle
// right after the result handshake; a start in that cycle is accepted.
//
// Optional feature (macro PE_CTRL_PERF_EN): adds a 32-bit saturating stall
// counter output, stall_cnt, counting LOAD cycles without in_valid plus OUT
// cycles without out_ready. Cleared by reset only.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset, aborts any job
//   start      job request, honoured only in IDLE
//   k_len      operand count, latched on accepted start
//   act_en     1 = route activated result, latched on accepted start
//   in_valid   operand stream valid
//   in_ready   operand stream ready (LOAD only)
//   acc_clr    accumulator clear strobe (CLR only)
//   acc_en     accumulator enable = in_valid & in_ready
//   mux_sel    PE output mux select (0 raw, 1 activated)
//   out_valid  result valid (OUT only)
//   out_ready  result consumer ready
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the result handshake
//   stall_cnt  stall cycle counter (PE_CTRL_PERF_EN builds only)
// -----------------------------------------------------------------------------
module pe_ctrl
  import pe_pkg::*;
#(
  parameter int K_W     = K_W_DEF,
  parameter int ACT_LAT = ACT_LAT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [K_W-1:0] k_len,
  input  logic           act_en,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           acc_clr,
  output logic           acc_en,
  output logic           mux_sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           done
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]    stall_cnt
`endif
);

  localparam int                 ACT_W    = cnt_width(ACT_LAT);
  localparam logic [ACT_W-1:0]   ACT_LOAD = ACT_W'(ACT_LAT);

  state_t state, state_nxt;
  logic   act_q;
  logic   done_q;

  logic   rem_zero, rem_one, rem_load, rem_dec;
  logic   wait_zero, wait_one, wait_load, wait_dec;
  logic   accept;

  assign accept = (state == ST_IDLE) && start;

  // ---------------------------------------------------------------------------
  // Counters: operands remaining, and activation wait cycles remaining.
  // ---------------------------------------------------------------------------
  assign rem_load = accept;
  assign rem_dec  = acc_en && !rem_zero;

  pe_cnt #(.W(K_W)) u_rem_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rem_load),
    .load_val (k_len),
    .dec      (rem_dec),
    .zero     (rem_zero),
    .one      (rem_one)
  );

  // Loaded with ACT_LAT on the edge into ACT; ACT is left in the cycle the
  // count reads one, so the state lasts exactly ACT_LAT cycles.
  assign wait_load = (state_nxt == ST_ACT) && (state != ST_ACT);
  assign wait_dec  = (state == ST_ACT) && !wait_zero;

  pe_cnt #(.W(ACT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wait_load),
    .load_val (ACT_LOAD),
    .dec      (wait_dec),
    .zero     (wait_zero),
    .one      (wait_one)
  );

  // ---------------------------------------------------------------------------
  // FSM state and job registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      act_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == ST_OUT) && out_ready;
      if (accept) begin
        act_q <= act_en;
      end
    end
  end

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    acc_clr   = 1'b0;
    mux_sel   = 1'b0;
    out_valid = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLR;
      end

      ST_CLR: begin
        acc_clr = 1'b1;
        if (!rem_zero)  state_nxt = ST_LOAD;
        else if (act_q) state_nxt = ST_ACT;
        else            state_nxt = ST_OUT;
      end

      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && rem_one) state_nxt = act_q ? ST_ACT : ST_OUT;
      end

      ST_ACT: begin
        mux_sel = 1'b1;
        if (wait_one) state_nxt = ST_OUT;
      end

      ST_OUT: begin
        out_valid = 1'b1;
        mux_sel   = act_q;
        if (out_ready) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign acc_en = in_valid && in_ready;
  assign busy   = (state != ST_IDLE);
  assign done   = done_q;

  // ---------------------------------------------------------------------------
  // Optional stall counter
  // ---------------------------------------------------------------------------
`ifdef PE_CTRL_PERF_EN
  logic stall;

  assign stall = ((state == ST_LOAD) && !in_valid) ||
                 ((state == ST_OUT)  && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_ctrl -- self-checking bench for pe_ctrl.
//
// Each job is described at the level of its phases (start, clear, k beats with
// optional gaps, ACT_LAT activation cycles, output wait, handshake, done) and
// expanded into a per-cycle script of stimulus and expected outputs. Inputs
// that should be ignored in a given cycle are randomized.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pe_ctrl;

  localparam int K_W     = 8;
  localparam int ACT_LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [K_W-1:0] k_len;
  logic           act_en;
  logic           in_valid;
  logic           in_ready;
  logic           acc_clr;
  logic           acc_en;
  logic           mux_sel;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic           done;
`ifdef PE_CTRL_PERF_EN
  logic [31:0]    stall_cnt;
`endif

  pe_ctrl #(.K_W(K_W), .ACT_LAT(ACT_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .act_en    (act_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .mux_sel   (mux_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef PE_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output vector: {acc_clr, in_ready, acc_en, mux_sel, out_valid, busy, done}
  logic [6:0] obs_vec;
  assign obs_vec = {acc_clr, in_ready, acc_en, mux_sel, out_valid, busy, done};

  typedef struct {
    logic           start;
    logic [K_W-1:0] k;
    logic           act;
    logic           in_valid;
    logic           out_ready;
    logic [6:0]     exp;
  } cyc_t;

  cyc_t script[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  bit   pending_done = 0;
  int   obs_en, obs_clr, obs_act, obs_done;

  function automatic logic [6:0] ev(input bit clr, input bit rdy, input bit en,
                                    input bit mux, input bit ov, input bit bsy);
    return {clr, rdy, en, mux, ov, bsy, 1'b0};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [K_W-1:0] rk();
    return K_W'($urandom);
  endfunction

  // Append one cycle; the done bit comes from the previous job's handshake.
  task automatic push(input logic st, input logic [K_W-1:0] k, input logic a,
                      input logic iv, input logic ordy, input logic [6:0] e);
    cyc_t c;
    c.start     = st;
    c.k         = k;
    c.act       = a;
    c.in_valid  = iv;
    c.out_ready = ordy;
    c.exp       = e | {6'b0, pending_done};
    pending_done = 0;
    script.push_back(c);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, rk(), rb(), rb(), rb(), ev(0, 0, 0, 0, 0, 0));
  endtask

  // gap >= 0: no gap before the first beat, 'gap' idle cycles before the rest.
  // gap <  0: random 0..2 idle cycles before every beat.
  task automatic push_job(input int k, input bit act, input int gap,
                          input int ow, input bit noise);
    int g;
    push(1'b1, K_W'(k), act, rb(), rb(), ev(0, 0, 0, 0, 0, 0));
    push(noise & rb(), rk(), rb(), rb(), rb(), ev(1, 0, 0, 0, 0, 1));
    for (int i = 0; i < k; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
      for (int j = 0; j < g; j++) begin
        push(noise & rb(), rk(), rb(), 1'b0, rb(), ev(0, 1, 0, 0, 0, 1));
        exp_stall++;
      end
      push(noise & rb(), rk(), rb(), 1'b1, rb(), ev(0, 1, 1, 0, 0, 1));
    end
    if (act)
      for (int i = 0; i < ACT_LAT; i++)
        push(noise & rb(), rk(), rb(), rb(), rb(), ev(0, 0, 0, 1, 0, 1));
    for (int i = 0; i < ow; i++) begin
      push(noise & rb(), rk(), rb(), rb(), 1'b0, ev(0, 0, 0, act, 1, 1));
      exp_stall++;
    end
    push(noise & rb(), rk(), rb(), rb(), 1'b1, ev(0, 0, 0, act, 1, 1));
    pending_done = 1;
  endtask

  // Drive each scripted cycle after the falling edge, sample 1 ns later.
  task automatic run_script(input string name);
    int idx = 0;
    obs_en = 0; obs_clr = 0; obs_act = 0; obs_done = 0;
    while (script.size() > 0) begin
      cyc_t c;
      c = script.pop_front();
      @(negedge clk);
      start     = c.start;
      k_len     = c.k;
      act_en    = c.act;
      in_valid  = c.in_valid;
      out_ready = c.out_ready;
      #1;
      checks++;
      if (obs_vec !== c.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs {clr,rdy,en,mux,ov,busy,done}=%b required %b",
                 name, idx, obs_vec, c.exp);
      end
      if (acc_en === 1'b1) obs_en++;
      if (acc_clr === 1'b1) obs_clr++;
      if (mux_sel === 1'b1 && out_valid === 1'b0) obs_act++;
      if (done === 1'b1) obs_done++;
      idx++;
    end
  endtask

  task automatic check_stall(input string name);
`ifdef PE_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d required %0d", name, stall_cnt, exp_stall);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #12;
    checks++;
    if (obs_vec !== 7'b0) begin
      errors++;
      $display("FAIL reset outputs: got %b required %b", obs_vec, 7'b0);
    end
    check_stall("reset");
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3);
    run_script("idle_after_reset");
  endtask

  task automatic test_basic_act();
    push_job(4, 1'b1, 0, 0, 1'b0);
    push_idle(1);
    run_script("basic_act");
    checks++;
    if (obs_en !== 4) begin errors++; $display("FAIL basic_act acc_en pulses: got %0d required 4", obs_en); end
    checks++;
    if (obs_clr !== 1) begin errors++; $display("FAIL basic_act acc_clr pulses: got %0d required 1", obs_clr); end
    checks++;
    if (obs_act !== ACT_LAT) begin errors++; $display("FAIL basic_act act cycles: got %0d required %0d", obs_act, ACT_LAT); end
    checks++;
    if (obs_done !== 1) begin errors++; $display("FAIL basic_act done pulses: got %0d required 1", obs_done); end
  endtask

  task automatic test_gaps_raw();
    int stall_before = exp_stall;
    push_job(3, 1'b0, 2, 0, 1'b0);
    push_idle(1);
    run_script("gaps_raw");
    checks++;
    if (obs_en !== 3) begin errors++; $display("FAIL gaps_raw acc_en pulses: got %0d required 3", obs_en); end
    checks++;
    if (obs_act !== 0) begin errors++; $display("FAIL gaps_raw act cycles: got %0d required 0", obs_act); end
    checks++;
    if (exp_stall - stall_before !== 4) begin errors++; $display("FAIL gaps_raw stall plan: got %0d required 4", exp_stall - stall_before); end
    check_stall("gaps_raw");
  endtask

  task automatic test_zero_len();
    push_job(0, 1'b1, 0, 0, 1'b1);
    push_idle(1);
    run_script("zero_len");
    checks++;
    if (obs_en !== 0) begin errors++; $display("FAIL zero_len acc_en pulses: got %0d required 0", obs_en); end
    checks++;
    if (obs_act !== ACT_LAT) begin errors++; $display("FAIL zero_len act cycles: got %0d required %0d", obs_act, ACT_LAT); end
  endtask

  task automatic test_out_stall();
    push_job(2, 1'b1, -1, 5, 1'b1);
    push_idle(2);
    run_script("out_stall");
    checks++;
    if (obs_done !== 1) begin errors++; $display("FAIL out_stall done pulses: got %0d required 1", obs_done); end
    check_stall("out_stall");
  endtask

  task automatic test_reset_mid_job();
    push(1'b1, K_W'(6), 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
    push(1'b0, rk(), rb(), rb(), rb(), ev(1, 0, 0, 0, 0, 1));
    push(1'b1, rk(), rb(), 1'b1, rb(), ev(0, 1, 1, 0, 0, 1));
    push(1'b1, rk(), rb(), 1'b1, rb(), ev(0, 1, 1, 0, 0, 1));
    run_script("mid_job_prefix");
    @(negedge clk);
    in_valid = 1'b1;
    start    = 1'b1;
    #1;
    checks++;
    if (obs_vec !== ev(0, 1, 1, 0, 0, 1)) begin
      errors++;
      $display("FAIL mid_job third beat: got %b required %b", obs_vec, ev(0, 1, 1, 0, 0, 1));
    end
    #1 rst_n = 1'b0;
    #1;
    exp_stall    = 0;
    pending_done = 0;
    checks++;
    if (obs_vec !== 7'b0) begin
      errors++;
      $display("FAIL mid_job async reset outputs: got %b required %b", obs_vec, 7'b0);
    end
    check_stall("mid_job_reset");
    @(negedge clk);
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    push_job(6, 1'b0, -1, 1, 1'b1);
    push_idle(1);
    run_script("after_reset_job");
    checks++;
    if (obs_en !== 6) begin errors++; $display("FAIL after_reset_job acc_en pulses: got %0d required 6", obs_en); end
    check_stall("after_reset_job");
  endtask

  task automatic test_max_len();
    push_job((1 << K_W) - 1, 1'b0, 0, 0, 1'b1);
    push_idle(1);
    run_script("max_len");
    checks++;
    if (obs_en !== (1 << K_W) - 1) begin
      errors++;
      $display("FAIL max_len acc_en pulses: got %0d required %0d", obs_en, (1 << K_W) - 1);
    end
  endtask

  task automatic test_back_to_back();
    int total_k = 0;
    int jobs    = 25;
    for (int j = 0; j < jobs; j++) begin
      int k = int'($urandom_range(0, 7));
      total_k += k;
      push_job(k, rb(), -1, int'($urandom_range(0, 3)), 1'b1);
      if (rb()) push_idle(int'($urandom_range(1, 2)));
    end
    push_idle(1);
    run_script("back_to_back");
    checks++;
    if (obs_en !== total_k) begin errors++; $display("FAIL back_to_back acc_en pulses: got %0d required %0d", obs_en, total_k); end
    checks++;
    if (obs_clr !== jobs) begin errors++; $display("FAIL back_to_back acc_clr pulses: got %0d required %0d", obs_clr, jobs); end
    checks++;
    if (obs_done !== jobs) begin errors++; $display("FAIL back_to_back done pulses: got %0d required %0d", obs_done, jobs); end
    check_stall("back_to_back");
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    k_len     = '0;
    act_en    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;

    test_reset();
    test_basic_act();
    test_gaps_raw();
    test_zero_len();
    test_out_stall();
    test_reset_mid_job();
    test_max_len();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_ctrl.md
PE_CTRL -- requirements
Module: pe_ctrl

Interface
REQ-001 SHALL have parameter K_W, default 8, width of the operand-count field.
REQ-002 SHALL have parameter ACT_LAT, default 2, activation-unit latency in cycles (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  job request; honoured only in IDLE.
REQ-006 SHALL have port k_len  input  K_W  operand count per job; latched on accepted start.
REQ-007 SHALL have port act_en  input  1  1 = route activated result; latched on accepted start.
REQ-008 SHALL have port in_valid  input  1  operand-stream valid.
REQ-009 SHALL have port in_ready  output  1  operand-stream ready.
REQ-010 SHALL have port acc_clr  output  1  accumulator clear strobe.
REQ-011 SHALL have port acc_en  output  1  accumulator enable; equals in_valid & in_ready.
REQ-012 SHALL have port mux_sel  output  1  PE output mux select (0 raw, 1 activated).
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  result consumer ready.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse, cycle after result handshake.

Function
REQ-017 SHALL implement FSM states IDLE, CLR, LOAD, ACT, OUT.
REQ-018 IDLE & start -> CLR; latches k_len into remaining counter and act_en into act_q.
REQ-019 CLR: acc_clr=1 for exactly one cycle; -> LOAD if k_len!=0, else -> ACT (act_q=1) or OUT (act_q=0).
REQ-020 LOAD: in_ready=1; each in_valid&in_ready beat decrements remaining; beat at remaining==1 -> ACT (act_q=1) or OUT (act_q=0).
REQ-021 LOAD with in_valid=0: hold state and counter, acc_en=0.
REQ-022 ACT: wait-counter runs ACT_LAT cycles, then -> OUT; mux_sel=1 throughout.
REQ-023 OUT: out_valid=1, mux_sel=act_q; hold until out_valid&out_ready, then -> IDLE.
REQ-024 in_ready, acc_en, acc_clr SHALL be 0 outside LOAD/CLR as specified; mux_sel=0 in IDLE, CLR, LOAD.
REQ-025 start outside IDLE SHALL be ignored (no queueing); start in the done cycle (IDLE) SHALL be accepted.
REQ-026 Counters SHALL not wrap: k_len=2^K_W-1 processes exactly that many beats.

Reset
REQ-027 rst_n low SHALL force IDLE asynchronously, mid-job included; job discarded.
REQ-028 Reset values: in_ready=0, acc_clr=0, acc_en=0, mux_sel=0, out_valid=0, busy=0, done=0, counters=0, act_q=0.

Configuration
REQ-029 PE_CTRL_PERF_EN defined: SHALL add output stall_cnt (32 bits), counting cycles in LOAD with in_valid=0 plus cycles in OUT with out_ready=0; saturates at all-ones; cleared by reset only.
REQ-030 PE_CTRL_PERF_EN undefined: stall_cnt port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package pe_pkg SHALL hold the FSM state enum and default K_W/ACT_LAT constants.
REQ-032 Sub-module pe_cnt (loadable down-counter with zero flag) SHALL implement both the remaining and ACT wait counters.

Verification
REQ-033 k_len=4, act_en=1, in_valid constant 1, out_ready=1 -> acc_clr 1 cycle, 4 acc_en, 2 ACT cycles, out_valid 1 cycle with mux_sel=1, done next cycle.
REQ-034 k_len=3, act_en=0, in_valid gaps of 2 cycles -> exactly 3 acc_en, no ACT state, mux_sel=0 at out_valid; PERF build stall_cnt=4.
REQ-035 k_len=0, act_en=1 -> CLR then ACT then OUT, zero acc_en pulses.
REQ-036 out_ready low 5 cycles in OUT -> out_valid and mux_sel held stable, start pulses ignored, done only after handshake.
REQ-037 rst_n low during LOAD after 2 of 6 beats -> all outputs reset values immediately; next start runs full 6 beats.
